eth_csr_arbiter: RTL

Round-robin AXI4-Lite arbiter that shares the single Ethernet CSR slave port (`eth_csr_mosi_i`/`eth_csr_miso_o` of `ethernet_wrapper`) between two requesters: the host CPU and the packet DMA engine. It serializes whole transactions, so at most one read or write is outstanding on the CSR port. It sits in the `clk_axi` domain, directly in front of the wrapper's CSR interface.

---
 rtl/eth_csr_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/eth_csr_arbiter.sv
// Two-requester round-robin AXI4-Lite arbiter in front of the Ethernet CSR slave.
// Latency: one cycle from request in IDLE to forwarded valid; passthrough afterwards.
// Backpressure: ready/valid passed combinationally; the loser sees ready=0 until granted.

package amba_axi_pkg;
  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_ID_W   = 4;

  typedef struct packed {
    logic [AXIL_ID_W-1:0]     awid;
    logic [AXIL_ADDR_W-1:0]   awaddr;
    logic [2:0]               awprot;
    logic                     awvalid;
    logic [AXIL_DATA_W-1:0]   wdata;
    logic [AXIL_DATA_W/8-1:0] wstrb;
    logic                     wvalid;
    logic                     bready;
    logic [AXIL_ID_W-1:0]     arid;
    logic [AXIL_ADDR_W-1:0]   araddr;
    logic [2:0]               arprot;
    logic                     arvalid;
    logic                     rready;
  } s_axil_mosi_t;

  typedef struct packed {
    logic                     awready;
    logic                     wready;
    logic [AXIL_ID_W-1:0]     bid;
    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     arready;
    logic [AXIL_ID_W-1:0]     rid;
    logic [AXIL_DATA_W-1:0]   rdata;
    logic [1:0]               rresp;
    logic                     rvalid;
  } s_axil_miso_t;
endpackage

module eth_csr_arbiter
  import amba_axi_pkg::*;
(
  input  logic         clk_axi,
  input  logic         rst_axi,
  input  s_axil_mosi_t m0_mosi_i,
  output s_axil_miso_t m0_miso_o,
  input  s_axil_mosi_t m1_mosi_i,
  output s_axil_miso_t m1_miso_o,
  output s_axil_mosi_t csr_mosi_o,
  input  s_axil_miso_t csr_miso_i,
  output logic         busy_o,
  output logic         grant_o
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_e;

  state_e       state_q;
  logic         rr_q;
  logic         grant_q;
  logic         busy_q;
  logic         aw_done_q;
  logic         w_done_q;

  s_axil_mosi_t sel_mosi;
  s_axil_miso_t gnt_miso;
  s_axil_miso_t nogrant_miso;
  logic         req0, req1, win;
  logic         aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign busy_o  = busy_q;
  assign grant_o = grant_q;

  assign sel_mosi = grant_q ? m1_mosi_i : m0_mosi_i;
  assign req0     = m0_mosi_i.awvalid | m0_mosi_i.arvalid;
  assign req1     = m1_mosi_i.awvalid | m1_mosi_i.arvalid;
  // Contention resolved by the pointer; a lone requester always wins.
  assign win      = (req0 && req1) ? rr_q : req1;

  // Forward the granted requester; valids/readys gated by state and done flags.
  always_comb begin
    csr_mosi_o         = sel_mosi;
    csr_mosi_o.awvalid = (state_q == WR_REQ) && sel_mosi.awvalid && !aw_done_q;
    csr_mosi_o.wvalid  = (state_q == WR_REQ) && sel_mosi.wvalid  && !w_done_q;
    csr_mosi_o.bready  = (state_q == WR_RESP) && sel_mosi.bready;
    csr_mosi_o.arvalid = (state_q == RD_REQ) && sel_mosi.arvalid;
    csr_mosi_o.rready  = (state_q == RD_RESP) && sel_mosi.rready;
  end

  // Return slave readys/valids to the granted requester only; data always mirrors the slave.
  always_comb begin
    gnt_miso             = csr_miso_i;
    gnt_miso.awready     = (state_q == WR_REQ) && csr_miso_i.awready && !aw_done_q;
    gnt_miso.wready      = (state_q == WR_REQ) && csr_miso_i.wready  && !w_done_q;
    gnt_miso.bvalid      = (state_q == WR_RESP) && csr_miso_i.bvalid;
    gnt_miso.arready     = (state_q == RD_REQ) && csr_miso_i.arready;
    gnt_miso.rvalid      = (state_q == RD_RESP) && csr_miso_i.rvalid;
    nogrant_miso         = csr_miso_i;
    nogrant_miso.awready = 1'b0;
    nogrant_miso.wready  = 1'b0;
    nogrant_miso.bvalid  = 1'b0;
    nogrant_miso.arready = 1'b0;
    nogrant_miso.rvalid  = 1'b0;
    m0_miso_o            = grant_q ? nogrant_miso : gnt_miso;
    m1_miso_o            = grant_q ? gnt_miso : nogrant_miso;
  end

  assign aw_hs = csr_mosi_o.awvalid && csr_miso_i.awready;
  assign w_hs  = csr_mosi_o.wvalid  && csr_miso_i.wready;
  assign b_hs  = csr_mosi_o.bready  && csr_miso_i.bvalid;
  assign ar_hs = csr_mosi_o.arvalid && csr_miso_i.arready;
  assign r_hs  = csr_mosi_o.rready  && csr_miso_i.rvalid;

  // Transaction FSM: grant, track AW/W completion, hand the pointer over on response.
  always_ff @(posedge clk_axi or negedge rst_axi) begin
    if (!rst_axi) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      grant_q   <= 1'b0;
      busy_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            grant_q <= win;
            busy_q  <= 1'b1;
            // A winner with both write and read pending is served write-first.
            if (win ? m1_mosi_i.awvalid : m0_mosi_i.awvalid) state_q <= WR_REQ;
            else                                             state_q <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_q <= WR_RESP;
        end
        WR_RESP: begin
          if (b_hs) begin
            rr_q      <= ~grant_q;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        RD_REQ: begin
          if (ar_hs) state_q <= RD_RESP;
        end
        RD_RESP: begin
          if (r_hs) begin
            rr_q    <= ~grant_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
